waterfall_mode_ctrl: RTL and testbench
======================================

Name: waterfall_mode_ctrl

Overview:
- Upstream controller for the 8-bit LED shift-register stage.
- Turns two raw push-buttons and a speed select into per-step shift commands: mode code {S1,S0}, load data D and a one-cycle STEP enable.
- The downstream shift register advances only on cycles where STEP=1.
- Provides a prescaled step rate, debounced mode/pause control, and left, right and bounce sequencing.

Parameters:
- DIV, 16, base step period in CP cycles at SPEED=0; must be a power of two, at least 8.
- DB_CYCLES, 4, number of consecutive stable cycles needed to accept a button level.
- PATTERN, 8'b00000001, value loaded into the shift register on every LOAD.

Ports:
- CP  in  1  system clock; all logic is on the rising edge.
- CR  in  1  reset; synchronous, active-low.
- KEY_MODE  in  1  raw mode button, active-low, asynchronous to CP.
- KEY_PAUSE  in  1  raw pause button, active-low, asynchronous to CP.
- SPEED  in  2  step period = DIV >> SPEED cycles.
- S1  out  1  shift-register mode bit 1.
- S0  out  1  shift-register mode bit 0.
- D  out  8  parallel load data.
- STEP  out  1  one-cycle enable for the shift register.
- MODE  out  2  current mode, for status LEDs.

Behaviour:
- Reset (CR=0 at a CP edge):
  - S1=S0=0, D=PATTERN, STEP=0, MODE=0.
  - Prescaler=0, pos=0, dir=left, debouncers idle (level=1).
  - State=LOAD.
  - Reset asserted mid-step cancels the step in that cycle.
- Command codes: {S1,S0} 00=hold, 01=rotate left, 10=rotate right, 11=load D.
  - All outputs are registered.
  - {S1,S0} is non-zero only in cycles where STEP=1; otherwise it is 00.
- Prescaler:
  - Counts 0..LIM-1 with LIM = DIV>>SPEED; tick=1 on the cycle the count equals LIM-1, then it wraps to 0.
  - The comparison is count>=LIM-1, so a SPEED change that lowers LIM below the current count wraps on the next cycle with one tick.
  - The prescaler clears to 0 in LOAD.
- Debouncer, per key:
  - 2-flop synchronizer, then a stability counter.
  - The debounced level updates once the synchronized input has differed from it for DB_CYCLES consecutive cycles; any bounce restarts the count.
  - A press pulse (1 cycle) is emitted when the debounced level goes 1->0; release gives no pulse.
- Modes (MODE): 0=LEFT, 1=RIGHT, 2=BOUNCE, 3=FREEZE. A mode press advances MODE by 1, wrapping 3->0.
- FSM states:
  - LOAD:
    - Outputs STEP=1 with {S1,S0}=11 and D=PATTERN.
    - Sets pos=0 and dir=left.
    - Goes to RUN next cycle, unconditionally; ticks and pause presses in this cycle are ignored.
  - RUN, on a tick:
    - LEFT: STEP=1 with 01; pos=pos+1 mod 8.
    - RIGHT: STEP=1 with 10; pos=pos-1 mod 8.
    - BOUNCE, dir=left: STEP=1 with 01 and pos+1; when the new pos=7, dir flips to right.
    - BOUNCE, dir=right: STEP=1 with 10 and pos-1; when the new pos=0, dir flips to left.
    - FREEZE: STEP=0.
    - Pause press -> PAUSE.
  - PAUSE:
    - STEP=0 and the prescaler is held.
    - Pause press -> RUN; the prescaler resumes from its held count.
  - Mode press, from RUN or PAUSE -> LOAD next cycle, with MODE updated.
- Priority:
  - Reset > mode press > pause press > tick.
  - A mode and pause press in the same cycle: the mode press wins, the pause press is discarded, and the FSM goes LOAD->RUN.
  - A tick coinciding with any press produces no step in that cycle.
- Latency:
  - Press pulse -> LOAD output on the next CP edge.
  - Raw key edge -> press pulse takes 2 sync cycles + DB_CYCLES.

Decomposition:
- Shared package waterfall_pkg holds:
  - mode encodings MODE_LEFT/RIGHT/BOUNCE/FREEZE;
  - command codes CMD_HOLD/ROL/ROR/LOAD;
  - FSM state enum ST_LOAD/ST_RUN/ST_PAUSE.
- One sub-module: key_debounce (sync + stability counter + press pulse), instantiated twice.
- Prescaler and FSM live in the top.

Test Plan:
1. Reset release with DIV=16, SPEED=0 -> first cycle STEP=1, {S1,S0}=11, D=8'h01; then STEP=1 with 01 every 16 cycles; pos wraps 7->0 after 8 steps.
2. KEY_MODE low for 2 cycles then high (DB_CYCLES=4) -> no press pulse, MODE stays 0. KEY_MODE held low 10 cycles -> one pulse, LOAD next cycle, MODE=1, subsequent steps use code 10.
3. MODE=2 (BOUNCE) -> sequence of 7 steps with 01 (pos 1..7), then 7 steps with 10 (pos 6..0), then 01 again.
4. Pause press mid-period at prescaler count 5 -> STEP=0 indefinitely. Second press -> first tick after 10 more cycles, not 16.
5. Set SPEED 0->3 while the prescaler count is 9 -> tick on the next cycle, then every 2 cycles.
6. Mode and pause press pulses in the same cycle -> LOAD, then RUN, not paused. CR=0 during a tick cycle -> STEP=0 and all outputs at their reset values.

Source files
------------

// File: rtl/waterfall_pkg.sv
// Shared encodings for the LED waterfall controller: display modes,
// shift-register command codes and controller FSM states.
package waterfall_pkg;

    typedef enum logic [1:0] {
        MODE_LEFT   = 2'd0,
        MODE_RIGHT  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FREEZE = 2'd3
    } mode_e;

    // {S1,S0} as seen by the downstream shift register.
    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_ROL  = 2'b01,
        CMD_ROR  = 2'b10,
        CMD_LOAD = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stability counter for one active-low push-button;
// emits a one-cycle press pulse on each accepted 1->0 level change.
module key_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        // Any cycle where the input agrees with the accepted level restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/waterfall_mode_ctrl.sv
// Waterfall LED controller: debounced mode/pause buttons, prescaled step rate
// and left/right/bounce sequencing, driving registered shift-register commands.
module waterfall_mode_ctrl
    import waterfall_pkg::*;
#(
    parameter int          DIV       = 16,
    parameter int          DB_CYCLES = 4,
    parameter logic [7:0]  PATTERN   = 8'b0000_0001
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       KEY_MODE,
    input  logic       KEY_PAUSE,
    input  logic [1:0] SPEED,
    output logic       S1,
    output logic       S0,
    output logic [7:0] D,
    output logic       STEP,
    output logic [1:0] MODE
);
    localparam int CW = $clog2(DIV);

    logic          mode_press, pause_press;
    logic [CW-1:0] lim_m1;
    logic          tick;
    logic [2:0]    pos_inc, pos_dec;

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    cmd_e          cmd_q, cmd_d;
    logic          step_q, step_d;
    logic [7:0]    d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    pos_q, pos_d;
    logic          dir_q, dir_d;   // 0 = moving left, 1 = moving right

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_mode (
        .clk   (CP),
        .rst_n (CR),
        .key_n (KEY_MODE),
        .press (mode_press)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_pause (
        .clk   (CP),
        .rst_n (CR),
        .key_n (KEY_PAUSE),
        .press (pause_press)
    );

    // >= rather than == so a speed-up that leaves the count past the new limit wraps at once.
    assign lim_m1  = CW'((DIV >> SPEED) - 1);
    assign tick    = (cnt_q >= lim_m1);
    assign pos_inc = pos_q + 3'd1;
    assign pos_dec = pos_q - 3'd1;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cmd_d   = CMD_HOLD;
        step_d  = 1'b0;
        d_d     = PATTERN;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        case (state_q)
            ST_LOAD: begin
                step_d  = 1'b1;
                cmd_d   = CMD_LOAD;
                pos_d   = 3'd0;
                dir_d   = 1'b0;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = tick ? '0 : cnt_q + CW'(1);
                if (mode_press) begin
                    mode_d  = mode_e'(mode_q + 2'd1);
                    state_d = ST_LOAD;
                end else if (pause_press) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    case (mode_q)
                        MODE_LEFT: begin
                            step_d = 1'b1;
                            cmd_d  = CMD_ROL;
                            pos_d  = pos_inc;
                        end
                        MODE_RIGHT: begin
                            step_d = 1'b1;
                            cmd_d  = CMD_ROR;
                            pos_d  = pos_dec;
                        end
                        MODE_BOUNCE: begin
                            step_d = 1'b1;
                            if (!dir_q) begin
                                cmd_d = CMD_ROL;
                                pos_d = pos_inc;
                                if (pos_inc == 3'd7) dir_d = 1'b1;
                            end else begin
                                cmd_d = CMD_ROR;
                                pos_d = pos_dec;
                                if (pos_dec == 3'd0) dir_d = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_PAUSE: begin
                if (mode_press) begin
                    mode_d  = mode_e'(mode_q + 2'd1);
                    state_d = ST_LOAD;
                end else if (pause_press) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge CP) begin
        if (!CR) begin
            state_q <= ST_LOAD;
            mode_q  <= MODE_LEFT;
            cmd_q   <= CMD_HOLD;
            step_q  <= 1'b0;
            d_q     <= PATTERN;
            cnt_q   <= '0;
            pos_q   <= 3'd0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cmd_q   <= cmd_d;
            step_q  <= step_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
        end
    end

    assign S1   = cmd_q[1];
    assign S0   = cmd_q[0];
    assign D    = d_q;
    assign STEP = step_q;
    assign MODE = mode_q;

endmodule

// File: tb/tb_waterfall_mode_ctrl.sv
// Directed and randomized bench for waterfall_mode_ctrl, checked every cycle
// against a behavioural model of the button, prescaler and sequencing rules.
module tb_waterfall_mode_ctrl;
    localparam int         DIV = 16;
    localparam int         DB  = 4;
    localparam logic [7:0] PAT = 8'h01;

    logic       cp = 1'b0;
    logic       cr = 1'b0;
    logic       key_mode = 1'b1;
    logic       key_pause = 1'b1;
    logic [1:0] speed = 2'd0;
    logic       s1, s0, step;
    logic [7:0] d;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    waterfall_mode_ctrl #(.DIV(DIV), .DB_CYCLES(DB), .PATTERN(PAT)) dut (
        .CP        (cp),
        .CR        (cr),
        .KEY_MODE  (key_mode),
        .KEY_PAUSE (key_pause),
        .SPEED     (speed),
        .S1        (s1),
        .S0        (s0),
        .D         (d),
        .STEP      (step),
        .MODE      (mode)
    );

    always #5 cp = ~cp;

    // Reference model state
    bit          m_loading, m_paused, m_step;
    int          m_mode, m_cnt, m_pos, m_dir, m_cmd;
    logic [15:0] h_mode, h_pause;   // raw key samples, bit 0 = most recent edge
    bit          lvl_mode, lvl_pause, pr_mode, pr_pause;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepted level flips when the last DB synchronized samples all disagree with it.
    function automatic bit window_flip(input logic [15:0] h, input bit lvl);
        window_flip = 1'b1;
        for (int i = 1; i <= DB; i++)
            if (h[i] == lvl) window_flip = 1'b0;
    endfunction

    task automatic model_edge();
        int lim;
        bit tk, fm, fp;
        if (!cr) begin
            m_loading = 1; m_paused = 0; m_mode = 0; m_cnt = 0; m_pos = 0; m_dir = 1;
            m_step = 0; m_cmd = 0;
            h_mode = '1; h_pause = '1; lvl_mode = 1; lvl_pause = 1; pr_mode = 0; pr_pause = 0;
            return;
        end
        lim = DIV >> speed;
        tk = (m_cnt >= lim - 1);
        m_step = 0;
        m_cmd = 0;
        if (m_loading) begin
            m_step = 1; m_cmd = 3; m_pos = 0; m_dir = 1; m_cnt = 0;
            m_loading = 0; m_paused = 0;
        end else if (m_paused) begin
            if (pr_mode) begin
                m_mode = (m_mode + 1) % 4;
                m_loading = 1;
            end else if (pr_pause) begin
                m_paused = 0;
            end
        end else begin
            m_cnt = tk ? 0 : m_cnt + 1;
            if (pr_mode) begin
                m_mode = (m_mode + 1) % 4;
                m_loading = 1;
            end else if (pr_pause) begin
                m_paused = 1;
            end else if (tk && m_mode != 3) begin
                int mv;
                mv = (m_mode == 0) ? 1 : (m_mode == 1) ? -1 : m_dir;
                m_step = 1;
                m_cmd = (mv > 0) ? 1 : 2;
                m_pos = (m_pos + mv + 8) % 8;
                if (m_mode == 2) begin
                    if (m_pos == 7) m_dir = -1;
                    else if (m_pos == 0) m_dir = 1;
                end
            end
        end
        fm = window_flip(h_mode, lvl_mode);
        fp = window_flip(h_pause, lvl_pause);
        pr_mode = fm && lvl_mode;
        pr_pause = fp && lvl_pause;
        if (fm) lvl_mode = ~lvl_mode;
        if (fp) lvl_pause = ~lvl_pause;
        h_mode = {h_mode[14:0], key_mode};
        h_pause = {h_pause[14:0], key_pause};
    endtask

    task automatic cycle();
        @(posedge cp);
        model_edge();
        @(negedge cp);
        check("step", {31'd0, step}, {31'd0, m_step});
        check("cmd", {30'd0, s1, s0}, m_cmd);
        check("d", {24'd0, d}, {24'd0, PAT});
        check("mode", {30'd0, mode}, m_mode);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_step(input string tag, input int budget, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!step && n < budget);
        check({tag, "_seen"}, {31'd0, step}, 32'd1);
    endtask

    task automatic count_steps(input int n, output int c);
        c = 0;
        repeat (n) begin
            cycle();
            if (step) c++;
        end
    endtask

    initial begin
        int n, c;
        logic [1:0] exp_cmd;

        // Reset and first LOAD
        run(3);
        check("rst_step", {31'd0, step}, 32'd0);
        check("rst_cmd", {30'd0, s1, s0}, 32'd0);
        check("rst_mode", {30'd0, mode}, 32'd0);
        cr = 1'b1;
        cycle();
        check("load_step", {31'd0, step}, 32'd1);
        check("load_cmd", {30'd0, s1, s0}, 32'd3);
        check("load_d", {24'd0, d}, 32'h01);
        for (int i = 0; i < 9; i++) begin
            wait_step("left", 40, n);
            check("left_gap", n, 16);
            check("left_cmd", {30'd0, s1, s0}, 32'd1);
        end

        // Short glitch gives no press; long hold gives one
        key_mode = 1'b0;
        run(2);
        key_mode = 1'b1;
        run(12);
        check("glitch_mode", {30'd0, mode}, 32'd0);
        key_mode = 1'b0;
        run(8);
        check("press_load_step", {31'd0, step}, 32'd1);
        check("press_load_cmd", {30'd0, s1, s0}, 32'd3);
        check("press_mode", {30'd0, mode}, 32'd1);
        run(2);
        key_mode = 1'b1;
        wait_step("right", 40, n);
        check("right_cmd", {30'd0, s1, s0}, 32'd2);
        run(10);

        // Bounce sequence
        key_mode = 1'b0;
        run(8);
        check("bounce_mode", {30'd0, mode}, 32'd2);
        key_mode = 1'b1;
        for (int i = 0; i < 15; i++) begin
            exp_cmd = (i < 7 || i == 14) ? 2'd1 : 2'd2;
            wait_step("bounce", 40, n);
            check("bounce_cmd", {30'd0, s1, s0}, {30'd0, exp_cmd});
        end

        // Pause mid-period, then resume from the held count
        run(15);
        key_pause = 1'b0;
        run(10);
        key_pause = 1'b1;
        count_steps(40, c);
        check("paused_steps", c, 0);
        key_pause = 1'b0;
        wait_step("resume", 40, n);
        check("resume_gap", n, 17);
        key_pause = 1'b1;

        // Speed-up with the count past the new limit
        run(9);
        speed = 2'd3;
        wait_step("speed_wrap", 10, n);
        check("speed_wrap_gap", n, 1);
        for (int i = 0; i < 3; i++) begin
            wait_step("fast", 10, n);
            check("fast_gap", n, 2);
        end

        // Freeze
        key_mode = 1'b0;
        run(8);
        check("freeze_mode", {30'd0, mode}, 32'd3);
        check("freeze_load", {31'd0, step}, 32'd1);
        key_mode = 1'b1;
        count_steps(30, c);
        check("freeze_steps", c, 0);

        // Simultaneous mode and pause presses
        key_mode = 1'b0;
        key_pause = 1'b0;
        run(8);
        check("both_load_cmd", {30'd0, s1, s0}, 32'd3);
        check("both_mode", {30'd0, mode}, 32'd0);
        key_mode = 1'b1;
        key_pause = 1'b1;
        wait_step("both_run", 10, n);
        check("both_gap", n, 2);
        check("both_cmd", {30'd0, s1, s0}, 32'd1);
        wait_step("both_run2", 10, n);
        check("both_gap2", n, 2);

        // Reset on a tick cycle
        cycle();
        cr = 1'b0;
        cycle();
        check("rst_tick_step", {31'd0, step}, 32'd0);
        check("rst_tick_cmd", {30'd0, s1, s0}, 32'd0);
        check("rst_tick_d", {24'd0, d}, 32'h01);
        check("rst_tick_mode", {30'd0, mode}, 32'd0);
        cycle();
        cr = 1'b1;
        cycle();
        check("rst_reload_cmd", {30'd0, s1, s0}, 32'd3);

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    key_mode = 1'b0;
                    run($urandom_range(1, 10));
                    key_mode = 1'b1;
                end
                3, 4, 5: begin
                    key_pause = 1'b0;
                    run($urandom_range(1, 10));
                    key_pause = 1'b1;
                end
                6: begin
                    key_mode = 1'b0;
                    key_pause = 1'b0;
                    run($urandom_range(1, 10));
                    key_mode = 1'b1;
                    key_pause = 1'b1;
                end
                7: speed = 2'($urandom_range(0, 3));
                8: begin
                    cr = 1'b0;
                    run($urandom_range(1, 2));
                    cr = 1'b1;
                end
                default: begin
                    for (int j = 0; j < 8; j++) begin
                        key_mode = 1'($urandom_range(0, 1));
                        key_pause = 1'($urandom_range(0, 1));
                        cycle();
                    end
                    key_mode = 1'b1;
                    key_pause = 1'b1;
                end
            endcase
            run($urandom_range(1, 30));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
